// File: rtl/pci_master_wbuf.sv
`timescale 1ns/1ps
// Purpose: AXI4 write-slave front end of the PCI master write path. Buffers W beats
//          in a circular word store, queues AW bursts, and issues one wcmd per complete burst.
// Latency: wcmd_valid one cycle after the wlast (or late AW) handshake; index read is combinational.
// Backpressure: wready drops when the buffer is full, awready when the AW FIFO is full,
//               wresp_ready when the 1-deep B register is held. Optional PCI_WBUF_LEN_CHECK_EN adds len_err.
module pci_master_wbuf #(
    parameter int BUF_AW = 10,
    parameter int CMD_AW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    // AXI AW channel
    input  logic [3:0]  s_awid,
    input  logic [63:0] s_awaddr,
    input  logic [7:0]  s_awlen,
    input  logic        s_awvalid,
    output logic        s_awready,
    // AXI W channel
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wlast,
    input  logic        s_wvalid,
    output logic        s_wready,
    // AXI B channel
    output logic [3:0]  s_bid,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    // command to pci_master_ctrl
    output logic [3:0]  wcmd_id,
    output logic [7:0]  wcmd_len,
    output logic [63:0] wcmd_addr,
    output logic        wcmd_valid,
    input  logic        wcmd_ready,
    // indexed buffer read from pci_master_ctrl
    input  logic [9:0]  wdata_idx,
    output logic [31:0] wdata_dout,
    output logic [3:0]  wdata_strb,
    // completion from pci_master_ctrl
    input  logic [3:0]  wresp_id,
    input  logic [7:0]  wresp_len,
    input  logic [1:0]  wresp_err,
    input  logic        wresp_valid,
    output logic        wresp_ready
`ifdef PCI_WBUF_LEN_CHECK_EN
    ,
    output logic        len_err
`endif
);

    localparam int DEPTH     = 1 << BUF_AW;
    localparam int CMD_DEPTH = 1 << CMD_AW;

    typedef struct packed {
        logic [3:0]  id;
        logic [7:0]  len;
        logic [63:0] addr;
    } aw_ent_t;

    typedef struct packed {
        logic [3:0]  strb;
        logic [31:0] data;
    } word_t;

    // ---------------- storage ----------------
    word_t              r_mem [DEPTH];
    aw_ent_t            r_aw_fifo [CMD_DEPTH];

    // ---------------- state ----------------
    logic [BUF_AW:0]    r_wr_ptr;
    logic [BUF_AW:0]    r_free_ptr;
    logic [CMD_AW:0]    r_aw_wp;
    logic [CMD_AW:0]    r_aw_rp;
    logic [CMD_AW:0]    r_done_cnt;
    logic               r_bvalid;
    logic [3:0]         r_bid;
    logic [1:0]         r_bresp;

    // ---------------- derived ----------------
    logic [BUF_AW:0]    w_used;
    logic               w_buf_full;
    logic [CMD_AW:0]    w_aw_cnt;
    logic               w_aw_full;
    logic               w_aw_nonempty;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_wlast_hs;
    logic               w_cmd_hs;
    logic               w_resp_hs;
    logic [BUF_AW-1:0]  w_rd_idx;
    word_t              w_rd_word;
    aw_ent_t            w_head;
    logic [BUF_AW:0]    w_free_inc;

    // Full means the pointers are exactly one buffer apart; the extra MSB disambiguates from empty.
    assign w_used        = r_wr_ptr - r_free_ptr;
    assign w_buf_full    = (w_used == (BUF_AW+1)'(DEPTH));
    assign w_aw_cnt      = r_aw_wp - r_aw_rp;
    assign w_aw_full     = (w_aw_cnt == (CMD_AW+1)'(CMD_DEPTH));
    assign w_aw_nonempty = (r_aw_wp != r_aw_rp);

    // Readies are held low while reset is asserted so nothing is accepted during reset.
    assign s_awready   = rst_n && !w_aw_full;
    assign s_wready    = rst_n && !w_buf_full;
    assign wresp_ready = !r_bvalid || s_bready;

    assign w_aw_hs    = s_awvalid && s_awready;
    assign w_w_hs     = s_wvalid && s_wready;
    assign w_wlast_hs = w_w_hs && s_wlast;
    assign w_cmd_hs   = wcmd_valid && wcmd_ready;
    assign w_resp_hs  = wresp_valid && wresp_ready;

    // A command needs both its AW and at least one fully buffered burst.
    assign w_head     = r_aw_fifo[r_aw_rp[CMD_AW-1:0]];
    assign wcmd_valid = w_aw_nonempty && (r_done_cnt != '0);
    assign wcmd_id    = w_head.id;
    assign wcmd_len   = w_head.len;
    assign wcmd_addr  = w_head.addr;

    // Zero-latency indexed read for the controller.
    assign w_rd_idx   = BUF_AW'(wdata_idx);
    assign w_rd_word  = r_mem[w_rd_idx];
    assign wdata_dout = w_rd_word.data;
    assign wdata_strb = w_rd_word.strb;

    assign s_bvalid = r_bvalid;
    assign s_bid    = r_bid;
    assign s_bresp  = r_bresp;

    // Completed bursts release len+1 words.
    assign w_free_inc = (BUF_AW+1)'({1'b0, wresp_len}) + (BUF_AW+1)'(1);

    // Beat store: data plus strobes, written at the write pointer.
    always_ff @(posedge clk) begin
        if (w_w_hs) begin
            r_mem[r_wr_ptr[BUF_AW-1:0]] <= word_t'({s_wstrb, s_wdata});
        end
    end

    // AW FIFO entry storage.
    always_ff @(posedge clk) begin
        if (w_aw_hs) begin
            r_aw_fifo[r_aw_wp[CMD_AW-1:0]] <= aw_ent_t'({s_awid, s_awlen, s_awaddr});
        end
    end

    // Buffer pointers; a write and a free in the same cycle both apply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_free_ptr <= '0;
        end else begin
            if (w_w_hs) begin
                r_wr_ptr <= r_wr_ptr + (BUF_AW+1)'(1);
            end
            if (w_resp_hs) begin
                r_free_ptr <= r_free_ptr + w_free_inc;
            end
        end
    end

    // AW FIFO pointers: push on AW handshake, pop when the command is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aw_wp <= '0;
            r_aw_rp <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_wp <= r_aw_wp + (CMD_AW+1)'(1);
            end
            if (w_cmd_hs) begin
                r_aw_rp <= r_aw_rp + (CMD_AW+1)'(1);
            end
        end
    end

    // Count of fully buffered bursts not yet issued as commands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
        end else begin
            case ({w_wlast_hs, w_cmd_hs})
                2'b10:   r_done_cnt <= r_done_cnt + (CMD_AW+1)'(1);
                2'b01:   r_done_cnt <= r_done_cnt - (CMD_AW+1)'(1);
                default: r_done_cnt <= r_done_cnt;
            endcase
        end
    end

    // One-deep B register: a new completion reloads it, bready alone drains it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bvalid <= 1'b0;
            r_bid    <= '0;
            r_bresp  <= '0;
        end else if (w_resp_hs) begin
            r_bvalid <= 1'b1;
            r_bid    <= wresp_id;
            r_bresp  <= wresp_err;
        end else if (s_bready) begin
            r_bvalid <= 1'b0;
        end
    end

`ifdef PCI_WBUF_LEN_CHECK_EN
    // Burst-length checker. r_chk_ptr walks the AW FIFO one burst per wlast; it can run ahead
    // of the AW write pointer when W leads AW, in which case the beat is not checked.
    logic [CMD_AW:0] r_chk_ptr;
    logic [8:0]      r_beat_cnt;
    logic            r_len_err;
    logic [CMD_AW:0] w_chk_diff;
    logic            w_chk_avail;
    logic [8:0]      w_chk_len;
    logic            w_len_bad;

    assign w_chk_diff  = r_aw_wp - r_chk_ptr;
    assign w_chk_avail = (w_chk_diff != '0) && (w_chk_diff <= (CMD_AW+1)'(CMD_DEPTH));
    assign w_chk_len   = {1'b0, r_aw_fifo[r_chk_ptr[CMD_AW-1:0]].len};
    assign w_len_bad   = w_chk_avail &&
                         ((s_wlast && (r_beat_cnt != w_chk_len)) ||
                          (!s_wlast && (r_beat_cnt >= w_chk_len)));
    assign len_err     = r_len_err;

    // Beat index within the current burst, sticky error flag, burst pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chk_ptr  <= '0;
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
        end else if (w_w_hs) begin
            if (w_len_bad) begin
                r_len_err <= 1'b1;
            end
            if (s_wlast) begin
                r_beat_cnt <= '0;
                r_chk_ptr  <= r_chk_ptr + (CMD_AW+1)'(1);
            end else if (r_beat_cnt != 9'h1FF) begin
                r_beat_cnt <= r_beat_cnt + 9'd1;
            end
        end
    end
`endif

endmodule
